// File: rtl/lfsr_crc_pkg.sv
// lfsr_crc_pkg: shared definitions for the parametrised LFSR CRC engine.
//   - crc_state_e : FSM encoding (IDLE=0, CALC=1, SHIFT=2)
//   - default tap mask / seed constants (legacy 8-bit generator values)
//   - crc_cnt_width(): width of the read-out bit counter
package lfsr_crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    SHIFT = 2'd2
  } crc_state_e;

  localparam logic [31:0] LFSR_CRC_DEFAULT_TAPS = 32'h0000_000C;
  localparam logic [31:0] LFSR_CRC_DEFAULT_SEED = 32'h0000_00D8;

  // Counter only has to reach crc_width-1; keep at least one bit.
  function automatic int crc_cnt_width(input int crc_width);
    return (crc_width <= 2) ? 1 : $clog2(crc_width);
  endfunction

endpackage

// File: rtl/lfsr_crc_step.sv
// lfsr_crc_step: combinational DATA_WIDTH-step LFSR update.
// Applies the single-bit step DATA_WIDTH times, i_data[0] first:
//   fb = d ^ R[0]; R'[W-1] = fb; R'[i] = R[i+1] ^ (TAPS[i] & fb)
// Ports:
//   i_r    [CRC_WIDTH-1:0]  current register value
//   i_data [DATA_WIDTH-1:0] message beat
//   o_r    [CRC_WIDTH-1:0]  register value after the whole beat
module lfsr_crc_step
  import lfsr_crc_pkg::*;
#(
  parameter int                   CRC_WIDTH  = 8,
  parameter int                   DATA_WIDTH = 1,
  parameter logic [CRC_WIDTH-1:0] TAPS       = CRC_WIDTH'(LFSR_CRC_DEFAULT_TAPS)
) (
  input  logic [CRC_WIDTH-1:0]  i_r,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [CRC_WIDTH-1:0]  o_r
);

  // w_stage[k] is the register after k message bits.
  logic [CRC_WIDTH-1:0] w_stage [0:DATA_WIDTH];
  logic [DATA_WIDTH-1:0] w_fb;

  assign w_stage[0] = i_r;

  for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_bit
    assign w_fb[k] = i_data[k] ^ w_stage[k][0];
    // The top tap bit is never used: bit W-1 always takes fb directly.
    assign w_stage[k+1] = {w_fb[k],
                           w_stage[k][CRC_WIDTH-1:1] ^
                           (TAPS[CRC_WIDTH-2:0] & {(CRC_WIDTH-1){w_fb[k]}})};
  end

  assign o_r = w_stage[DATA_WIDTH];

endmodule

// File: rtl/lfsr_crc_param.sv
// lfsr_crc_param: parametrised LFSR CRC generator with serial read-out.
// Absorbs DATA_WIDTH message bits per cycle while ACTIVE is high, then
// shifts the CRC out LSB-first on CRC with VALID/BUSY high for CRC_WIDTH
// cycles, and reloads SEED.
// Handshake: the source presents one beat per cycle with ACTIVE=1; a
// message ends on the first cycle ACTIVE=0. While BUSY=1 ACTIVE is
// ignored; the source must wait for BUSY=0 before the next message.
// Ports:
//   CLK, RST (async, active-high)
//   DATA [DATA_WIDTH-1:0], ACTIVE : message input
//   CRC, VALID, BUSY              : registered serial output
// Optional (macro LFSR_CRC_PAR_OUT_EN):
//   CRC_WORD [CRC_WIDTH-1:0] : final register, loaded on entry to SHIFT
//   CRC_DONE                 : one-cycle pulse with the first VALID cycle
module lfsr_crc_param
  import lfsr_crc_pkg::*;
#(
  parameter int                   CRC_WIDTH  = 8,
  parameter int                   DATA_WIDTH = 1,
  parameter logic [CRC_WIDTH-1:0] TAPS       = CRC_WIDTH'(LFSR_CRC_DEFAULT_TAPS),
  parameter logic [CRC_WIDTH-1:0] SEED       = CRC_WIDTH'(LFSR_CRC_DEFAULT_SEED)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] DATA,
  input  logic                  ACTIVE,
  output logic                  CRC,
  output logic                  VALID,
  output logic                  BUSY
`ifdef LFSR_CRC_PAR_OUT_EN
  ,
  output logic [CRC_WIDTH-1:0]  CRC_WORD,
  output logic                  CRC_DONE
`endif
);

  localparam int             CW       = crc_cnt_width(CRC_WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CRC_WIDTH - 1);

  crc_state_e           r_state, w_state_nxt;
  logic [CRC_WIDTH-1:0] r_r, w_r_nxt, w_step;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic                 r_crc, w_crc_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_busy, w_busy_nxt;

  lfsr_crc_step #(
    .CRC_WIDTH  (CRC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .TAPS       (TAPS)
  ) u_step (
    .i_r    (r_r),
    .i_data (DATA),
    .o_r    (w_step)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_r     <= SEED;
      r_cnt   <= '0;
      r_crc   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_r     <= w_r_nxt;
      r_cnt   <= w_cnt_nxt;
      r_crc   <= w_crc_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_r_nxt     = r_r;
    w_cnt_nxt   = r_cnt;
    w_crc_nxt   = 1'b0;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        // r_busy is still high during the last read-out bit; a beat
        // offered then is ignored.
        if (ACTIVE && !r_busy) begin
          w_r_nxt     = w_step;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        if (ACTIVE) begin
          w_r_nxt = w_step;
        end else begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        w_crc_nxt   = r_r[0];
        w_valid_nxt = 1'b1;
        w_busy_nxt  = 1'b1;
        w_r_nxt     = r_r >> 1;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_r_nxt     = SEED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_r_nxt     = SEED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign CRC   = r_crc;
  assign VALID = r_valid;
  assign BUSY  = r_busy;

`ifdef LFSR_CRC_PAR_OUT_EN
  logic [CRC_WIDTH-1:0] r_word;
  logic                 r_done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_word <= '0;
      r_done <= 1'b0;
    end else begin
      // CALC with ACTIVE low is the edge that enters SHIFT; r_r is final.
      if (r_state == CALC && !ACTIVE) begin
        r_word <= r_r;
      end
      r_done <= (r_state == SHIFT) && (r_cnt == '0);
    end
  end

  assign CRC_WORD = r_word;
  assign CRC_DONE = r_done;
`endif

endmodule

// File: tb/tb_lfsr_crc_param.sv
// tb_lfsr_crc_param: scoreboard bench for lfsr_crc_param.
// Three instances share clock and reset:
//   ch0: CRC 8, DATA_WIDTH 8, TAPS 0x0C, SEED 0x00
//   ch1: CRC 8, DATA_WIDTH 1, TAPS 0x0C, SEED 0x00
//   ch2: default parameters (DATA_WIDTH 1, TAPS 0x0C, SEED 0xD8)
// Expected CRC words are tagged with their channel and queued in exp_q;
// the monitor assembles serial words from VALID cycles and compares.
// Optional outputs checked when LFSR_CRC_PAR_OUT_EN is defined.
module tb_lfsr_crc_param;

  logic       clk;
  logic       rst;
  logic       act8, act1, actd;
  logic [7:0] data8;
  logic [0:0] data1, datad;
  logic       crc8, valid8, busy8;
  logic       crc1, valid1, busy1;
  logic       crcd, validd, busyd;
`ifdef LFSR_CRC_PAR_OUT_EN
  logic [7:0] word8, word1, wordd;
  logic       done8, done1, doned;
`endif

  int checks = 0;
  int errors = 0;

  // {channel, crc word}
  logic [9:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  lfsr_crc_param #(.CRC_WIDTH(8), .DATA_WIDTH(8), .TAPS(8'h0C), .SEED(8'h00)) u_dut8 (
    .CLK(clk), .RST(rst), .DATA(data8), .ACTIVE(act8),
    .CRC(crc8), .VALID(valid8), .BUSY(busy8)
`ifdef LFSR_CRC_PAR_OUT_EN
    , .CRC_WORD(word8), .CRC_DONE(done8)
`endif
  );

  lfsr_crc_param #(.CRC_WIDTH(8), .DATA_WIDTH(1), .TAPS(8'h0C), .SEED(8'h00)) u_dut1 (
    .CLK(clk), .RST(rst), .DATA(data1), .ACTIVE(act1),
    .CRC(crc1), .VALID(valid1), .BUSY(busy1)
`ifdef LFSR_CRC_PAR_OUT_EN
    , .CRC_WORD(word1), .CRC_DONE(done1)
`endif
  );

  lfsr_crc_param u_dutd (
    .CLK(clk), .RST(rst), .DATA(datad), .ACTIVE(actd),
    .CRC(crcd), .VALID(validd), .BUSY(busyd)
`ifdef LFSR_CRC_PAR_OUT_EN
    , .CRC_WORD(wordd), .CRC_DONE(doned)
`endif
  );

  logic mon_valid [3];
  logic mon_crc   [3];
  logic mon_busy  [3];
  assign mon_valid[0] = valid8;
  assign mon_valid[1] = valid1;
  assign mon_valid[2] = validd;
  assign mon_crc[0]   = crc8;
  assign mon_crc[1]   = crc1;
  assign mon_crc[2]   = crcd;
  assign mon_busy[0]  = busy8;
  assign mon_busy[1]  = busy1;
  assign mon_busy[2]  = busyd;

  // ---------------- scoreboard monitor ----------------
  logic [7:0] mon_word [3];
  int         mon_bits [3];

  initial begin
    logic [9:0] exp;
    for (int c = 0; c < 3; c++) begin
      mon_bits[c] = 0;
      mon_word[c] = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (rst) begin
          mon_bits[c] = 0;
        end else begin
          checks++;
          if (mon_busy[c] !== mon_valid[c]) begin
            errors++;
            $display("FAIL busy_ch%0d: busy=%b, required equal to valid=%b", c, mon_busy[c], mon_valid[c]);
          end
`ifdef LFSR_CRC_PAR_OUT_EN
          if (c == 0) begin
            checks++;
            if (done8 !== (valid8 && mon_bits[0] == 0)) begin
              errors++;
              $display("FAIL done_ch0: done=%b, required %b", done8, valid8 && mon_bits[0] == 0);
            end
            if (done8 === 1'b1 && exp_q.size() > 0) begin
              checks++;
              if (word8 !== exp_q[0][7:0]) begin
                errors++;
                $display("FAIL word_ch0: got %h, required %h", word8, exp_q[0][7:0]);
              end
            end
          end
`endif
          if (mon_valid[c] === 1'b1) begin
            mon_word[c][mon_bits[c]] = mon_crc[c];
            mon_bits[c]++;
            if (mon_bits[c] == 8) begin
              checks++;
              if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL crc_word_ch%0d: got %h, required no output", c, mon_word[c]);
              end else begin
                exp = exp_q.pop_front();
                if ({2'(c), mon_word[c]} !== exp) begin
                  errors++;
                  $display("FAIL crc_word_ch%0d: got ch%0d/%h, required ch%0d/%h",
                           c, c, mon_word[c], exp[9:8], exp[7:0]);
                end
              end
              mon_bits[c] = 0;
            end
          end else begin
            checks++;
            if (mon_bits[c] != 0 || mon_crc[c] !== 1'b0) begin
              errors++;
              $display("FAIL quiet_ch%0d: crc=%b after %0d valid bits, required crc=0 after 0 or 8 bits",
                       c, mon_crc[c], mon_bits[c]);
            end
            mon_bits[c] = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int ch, input logic act, input logic [7:0] d);
    case (ch)
      0:       begin act8 = act; data8 = d;    end
      1:       begin act1 = act; data1 = d[0]; end
      default: begin actd = act; datad = d[0]; end
    endcase
  endtask

  task automatic beat(input int ch, input logic [7:0] d);
    @(posedge clk); #1;
    drive(ch, 1'b1, d);
  endtask

  task automatic end_msg(input int ch);
    @(posedge clk); #1;
    drive(ch, 1'b0, 8'h00);
  endtask

  task automatic push_exp(input int ch, input logic [7:0] w);
    exp_q.push_back({2'(ch), w});
  endtask

  task automatic wait_busy(input int ch, input logic level);
    int n;
    n = 0;
    while (mon_busy[ch] !== level && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (mon_busy[ch] !== level) begin
      checks++;
      errors++;
      $display("FAIL wait_busy_ch%0d: busy=%b after 30 cycles, required %b", ch, mon_busy[ch], level);
    end
  endtask

  task automatic wait_readout(input int ch);
    wait_busy(ch, 1'b1);
    wait_busy(ch, 1'b0);
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if ({valid8, crc8, busy8, valid1, crc1, busy1, validd, crcd, busyd} !== 9'b0) begin
      errors++;
      $display("FAIL %s: outputs {v,c,b}x3=%b, required 000000000", name,
               {valid8, crc8, busy8, valid1, crc1, busy1, validd, crcd, busyd});
    end
  endtask

  // Called at posedge+1; asserts reset mid-cycle to exercise the async path.
  task automatic pulse_reset(input string name);
    #2 rst = 1'b1;
    #1 check_quiet(name);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    act8 = 1'b0; act1 = 1'b0; actd = 1'b0;
    data8 = 8'h00; data1 = 1'b0; datad = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_quiet("reset_state");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_quiet("after_reset");

    // Single 8-bit beat 0x01 -> 0x5E
    push_exp(0, 8'h5E);
    beat(0, 8'h01);
    end_msg(0);
    wait_readout(0);

    // Same message serially, bits 1,0,0,0,0,0,0,0 -> 0x5E
    push_exp(1, 8'h5E);
    for (int i = 0; i < 8; i++) beat(1, (i == 0) ? 8'h01 : 8'h00);
    end_msg(1);
    wait_readout(1);

    // All-zero message with zero seed -> 0x00
    push_exp(0, 8'h00);
    for (int i = 0; i < 3; i++) beat(0, 8'h00);
    end_msg(0);
    wait_readout(0);

    // ACTIVE asserted during read-out is ignored; back-to-back messages
    push_exp(0, 8'h5E);
    push_exp(0, 8'h5E);
    beat(0, 8'h01);
    end_msg(0);
    wait_busy(0, 1'b1);
    drive(0, 1'b1, 8'hFF);
    repeat (3) @(posedge clk);
    #1 drive(0, 1'b0, 8'h00);
    wait_busy(0, 1'b0);
    beat(0, 8'h01);
    end_msg(0);
    wait_readout(0);

    // Reset while bit 3 is presented, then a clean message
    beat(0, 8'h01);
    end_msg(0);
    wait_busy(0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    pulse_reset("reset_mid_shift_ch0");
    push_exp(0, 8'h5E);
    beat(0, 8'h01);
    end_msg(0);
    wait_readout(0);

    // Default instance, seed 0xD8: bit 1 -> 0xE0; bits 0,0 -> 0x36
    push_exp(2, 8'hE0);
    beat(2, 8'h01);
    end_msg(2);
    wait_readout(2);
    push_exp(2, 8'h36);
    beat(2, 8'h00);
    beat(2, 8'h00);
    end_msg(2);
    wait_readout(2);

    // Reset mid-read-out must restore the seed
    beat(2, 8'h01);
    end_msg(2);
    wait_busy(2, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    pulse_reset("reset_mid_shift_ch2");
    push_exp(2, 8'hE0);
    beat(2, 8'h01);
    end_msg(2);
    wait_readout(2);

    // No message for 50 cycles: monitor sees only quiet cycles
    repeat (50) @(posedge clk);
    #1 check_quiet("idle_50");

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_q_drain: %0d words outstanding, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_crc_param.md
Name: lfsr_crc_param

Overview:
- Parametrised successor to the team's 8-bit serial LFSR CRC generator.
- Generalisations:
  - configurable CRC width, tap set and seed;
  - consumes DATA_WIDTH message bits per clock (LSB-first within each beat);
  - unbounded multi-beat messages framed by ACTIVE;
  - serial CRC read-out framed by VALID, plus a BUSY back-pressure flag.
- Sits between a message source and a serial link framer; one CRC engine per message stream.

Parameters:
- CRC_WIDTH, 8: LFSR/CRC register width, 2..32.
- DATA_WIDTH, 1: message bits absorbed per clock, 1..32. Default 1 equals the legacy serial behaviour.
- TAPS, 8'h0C: tap mask. Bit i set means feedback XORs into register bit i, for i < CRC_WIDTH-1. Bit CRC_WIDTH-1 is ignored.
- SEED, 8'hD8: register value after reset and after every completed read-out.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- DATA  in  DATA_WIDTH  message beat; bit 0 is processed first.
- ACTIVE  in  1  high while message beats are presented, one beat per cycle.
- CRC  out  1  serial CRC, register bit 0 first.
- VALID  out  1  high while CRC carries a valid CRC bit.
- BUSY  out  1  high during read-out; ACTIVE is ignored while BUSY=1.

Behaviour:
- Single-bit step for input bit d on register R:
  - fb = d ^ R[0]
  - R'[CRC_WIDTH-1] = fb
  - R'[i] = R[i+1] ^ (TAPS[i] & fb), for i < CRC_WIDTH-1
- Per beat, the step is applied DATA_WIDTH times in one cycle, starting with DATA[0].
- Reset (async, any state, including mid-message or mid-read-out):
  - state = IDLE, R = SEED, shift counter = 0;
  - CRC = 0, VALID = 0, BUSY = 0.
- IDLE:
  - ACTIVE=1 sampled: absorb DATA into R (seeded), go to CALC.
  - ACTIVE=0: hold.
- CALC:
  - ACTIVE=1: absorb DATA, stay.
  - ACTIVE=0: go to SHIFT, count = 0.
- SHIFT:
  - Each cycle: CRC = R[0], VALID = 1, BUSY = 1; R shifts right with zero fill; count increments.
  - On the cycle presenting bit CRC_WIDTH-1: next state IDLE, R = SEED.
- Latency:
  - First CRC bit is registered out on the first rising edge after the edge that sampled ACTIVE=0.
  - VALID stays high for exactly CRC_WIDTH consecutive cycles.
  - Outputs are registered.
- ACTIVE=1 during SHIFT: ignored, no absorption, no restart. The source must wait for BUSY=0.
- ACTIVE=1 sampled in the cycle that leaves SHIFT: ignored. A new message starts from the next cycle in IDLE.
- Back-to-back messages need at least one cycle with ACTIVE=0 between them.
- Zero-length message (no ACTIVE pulse): no output.
- Counter width is $clog2(CRC_WIDTH); no wrap beyond CRC_WIDTH-1.
- CRC = 0 whenever VALID = 0.

Optional Feature:
- Macro: LFSR_CRC_PAR_OUT_EN
- Defined: adds output CRC_WORD [CRC_WIDTH-1:0] and output CRC_DONE (1).
  - CRC_WORD loads the final R in the same edge that enters SHIFT, and holds until the next such load. Reset value 0.
  - CRC_DONE pulses high for one cycle coincident with the first VALID cycle.
- Undefined: these ports and their registers do not exist; serial behaviour is identical.

Decomposition:
- Shared package lfsr_crc_pkg holds:
  - state encoding constants: IDLE=2'd0, CALC=2'd1, SHIFT=2'd2;
  - default TAPS/SEED constants;
  - a counter-width helper.
- One sub-module: lfsr_crc_step, a combinational unrolled DATA_WIDTH-step update taking (R, DATA) and producing R'. The top owns the FSM, counter and output registers.

Test Plan:
- Parameters CRC_WIDTH=8, DATA_WIDTH=8, TAPS=8'h0C, SEED=8'h00; one beat DATA=8'h01 then ACTIVE low -> CRC bits 0,1,1,1,1,0,1,0 (word 8'h5E) over 8 VALID cycles; CRC_WORD=8'h5E when the macro is on.
- Same data with DATA_WIDTH=1, bits 1,0,0,0,0,0,0,0 over 8 ACTIVE cycles -> identical serial output 8'h5E, proving width equivalence.
- SEED=8'h00, any-length all-zero message -> eight CRC bits of 0, VALID high exactly 8 cycles, then BUSY=0.
- Two messages of 8'h01 separated by one idle cycle, with ACTIVE asserted during the first read-out -> both CRCs are 8'h5E; the ACTIVE pulse during BUSY has no effect.
- Assert RST for one cycle during SHIFT at bit 3 -> immediately VALID=0, CRC=0, BUSY=0. The next message yields the correct CRC from SEED.
- Default parameters, ACTIVE never asserted for 50 cycles -> VALID=0 and CRC=0 throughout.
